// File: rtl/pser_pkg.sv
// rtl/pser_pkg.sv - serializer state encoding and PRBS7 constants
package pser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // x^7 + x^6 + 1: feedback taps on state bits 6 and 5
  localparam logic [6:0] PRBS7_TAPS = 7'h60;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

endpackage

// File: rtl/pser_prbs7.sv
// rtl/pser_prbs7.sv - PRBS7 generator advancing BITS bits per step, o_bits[0] is the oldest bit
module pser_prbs7 #(
  parameter int BITS = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_step,
  output logic [BITS-1:0] o_bits
);
  import pser_pkg::*;

  logic [6:0] r_state;
  logic [6:0] w_state_next;

  always_comb begin
    logic fb;
    w_state_next = r_state;
    o_bits       = '0;
    for (int i = 0; i < BITS; i++) begin
      fb           = ^(w_state_next & PRBS7_TAPS);
      o_bits[i]    = fb;
      w_state_next = {w_state_next[5:0], fb};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= PRBS7_SEED;
    end else if (i_step) begin
      r_state <= w_state_next;
    end
  end

endmodule

// File: rtl/pser_mux.sv
// rtl/pser_mux.sv - parallel-to-serial lane mux with a one-word input buffer
// Optional PRBS7 payload source enabled by macro PSER_PRBS_EN.
module pser_mux #(
  parameter int               WIDTH    = 16,
  parameter int               LANES    = 1,
  parameter logic [LANES-1:0] IDLE_PAT = '0
) (
  input  logic             clk_b,
  input  logic             rst,
`ifdef PSER_PRBS_EN
  input  logic             prbs_en,
`endif
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [LANES-1:0] dout,
  output logic             dout_valid,
  output logic             underrun
);
  import pser_pkg::*;

  localparam int RATIO = WIDTH / LANES;
  localparam int PW    = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(RATIO - 1);

  generate
    if ((WIDTH % LANES) != 0 || RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_cfg
      $error("pser_mux: WIDTH/LANES must be an integer power of two >= 2");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_buf;
  logic             r_buf_full;
  logic [WIDTH-1:0] r_shift;
  logic [PW-1:0]    r_phase;
  logic [LANES-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_underrun;
  logic             r_din_ready;

  logic             w_accept;
  logic             w_boundary;
  logic             w_use_prbs;
  logic             w_prbs_mode_next;
  logic [WIDTH-1:0] w_prbs_bits;
  logic             w_load_buf;
  logic             w_load;
  logic [WIDTH-1:0] w_load_word;
  logic             w_buf_full_next;

  assign w_accept        = din_valid & r_din_ready;
  assign w_boundary      = (r_state == ST_IDLE) || (r_phase == LAST_PHASE);
  assign w_load_buf      = w_boundary & ~w_use_prbs & r_buf_full;
  assign w_load          = w_load_buf | w_use_prbs;
  assign w_load_word     = w_use_prbs ? w_prbs_bits : r_buf;
  // A buffer drained on this edge may be refilled on the same edge
  assign w_buf_full_next = w_accept | (r_buf_full & ~w_load_buf);

`ifdef PSER_PRBS_EN
  logic r_prbs_act;

  assign w_use_prbs       = w_boundary & prbs_en;
  assign w_prbs_mode_next = w_boundary ? prbs_en : r_prbs_act;

  pser_prbs7 #(
    .BITS (WIDTH)
  ) u_prbs (
    .i_clk  (clk_b),
    .i_rst  (rst),
    .i_step (w_use_prbs),
    .o_bits (w_prbs_bits)
  );

  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) begin
      r_prbs_act <= 1'b0;
    end else begin
      r_prbs_act <= w_prbs_mode_next;
    end
  end
`else
  assign w_use_prbs       = 1'b0;
  assign w_prbs_mode_next = 1'b0;
  assign w_prbs_bits      = '0;
`endif

  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_buf        <= '0;
      r_buf_full   <= 1'b0;
      r_shift      <= '0;
      r_phase      <= '0;
      r_dout       <= IDLE_PAT;
      r_dout_valid <= 1'b0;
      r_underrun   <= 1'b0;
      r_din_ready  <= 1'b1;
    end else begin
      r_buf_full  <= w_buf_full_next;
      r_din_ready <= ~w_buf_full_next & ~w_prbs_mode_next;
      r_underrun  <= 1'b0;
      if (w_accept) begin
        r_buf <= din;
      end
      if (w_load) begin
        r_state      <= ST_SHIFT;
        r_shift      <= w_load_word;
        r_phase      <= '0;
        r_dout       <= w_load_word[LANES-1:0];
        r_dout_valid <= 1'b1;
      end else if (r_state == ST_SHIFT && !w_boundary) begin
        r_phase <= r_phase + 1'b1;
        r_shift <= r_shift >> LANES;
        r_dout  <= r_shift[2*LANES-1:LANES];
      end else begin
        r_underrun   <= (r_state == ST_SHIFT);
        r_state      <= ST_IDLE;
        r_phase      <= '0;
        r_dout       <= IDLE_PAT;
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign din_ready  = r_din_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign underrun   = r_underrun;

endmodule
